// File: rtl/clk_sel_sequencer_if.sv
// Request / status bundle between a clock-change requester and the
// clk_sel sequencer. The requester owns req_valid/req_sel; everything
// else is produced by the sequencer.
interface clk_sel_sequencer_if #(
    parameter int SWC_W = 16
);
    logic             req_valid;
    logic [1:0]       req_sel;
    logic             req_ready;
    logic [1:0]       clk_sel;
    logic             busy;
    logic             done;
    logic             changed;
    logic [SWC_W-1:0] sw_cnt;

    modport master (
        output req_valid,
        output req_sel,
        input  req_ready,
        input  clk_sel,
        input  busy,
        input  done,
        input  changed,
        input  sw_cnt
    );

    modport slave (
        input  req_valid,
        input  req_sel,
        output req_ready,
        output clk_sel,
        output busy,
        output done,
        output changed,
        output sw_cnt
    );
endinterface

// File: rtl/clk_sel_sequencer.sv
// Drives the 2-bit select of the glitch-free 800M/500M/1000M clock switch.
// Each accepted request updates clk_sel at most once, then clk_sel is held
// for SETTLE_CYC cycles while the switch completes its handover, followed by
// DWELL_CYC cycles before another request is taken. No-op requests complete
// in one cycle and never disturb clk_sel.
module clk_sel_sequencer #(
    parameter logic [1:0] RST_SEL    = 2'b00,
    parameter int          SETTLE_CYC = 8,
    parameter int          DWELL_CYC  = 16,
    parameter int          CNT_W      = 8,
    parameter int          SWC_W      = 16
) (
    input logic                 clk_500M,
    input logic                 rst_n,
    clk_sel_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETTLE = 2'b01,
        HOLD   = 2'b10
    } state_t;

    // The switch only understands 00/01/10; 1x always means the 1000M source.
    localparam logic [1:0]       RST_CANON   = RST_SEL[1] ? 2'b10 : RST_SEL;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD  = (DWELL_CYC == 0) ? '0 : CNT_W'(DWELL_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [1:0]       sel_q,   sel_d;
    logic             done_q,  done_d;
    logic             chg_q,   chg_d;
    logic [SWC_W-1:0] sw_q,    sw_d;

    logic       accept;
    logic [1:0] tgt;

    assign tgt    = bus.req_sel[1] ? 2'b10 : bus.req_sel;
    assign accept = bus.req_valid && (state_q == IDLE);

    // State and output registers; reset forces the switch back to its default source.
    always_ff @(posedge clk_500M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= RST_CANON;
            done_q  <= 1'b0;
            chg_q   <= 1'b0;
            sw_q    <= '0;
        end else begin
            // NOTE: non-blocking so every register sees the pre-edge values of the others.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
            chg_q   <= chg_d;
            sw_q    <= sw_d;
        end
    end

    // Next-state logic: accept in IDLE, count down the settle then dwell windows.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        chg_d   = 1'b0;
        sw_d    = sw_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (tgt == sel_q) begin
                        // Already on the requested source: complete immediately.
                        done_d = 1'b1;
                    end else begin
                        sel_d   = tgt;
                        cnt_d   = SETTLE_LOAD;
                        sw_d    = (&sw_q) ? sw_q : sw_q + 1'b1;
                        state_d = SETTLE;
                    end
                end
            end

            SETTLE: begin
                if (cnt_q == '0) begin
                    done_d = 1'b1;
                    chg_d  = 1'b1;
                    if (DWELL_CYC == 0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = DWELL_LOAD;
                        state_d = HOLD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.clk_sel   = sel_q;
    assign bus.done      = done_q;
    assign bus.changed   = chg_q;
    assign bus.sw_cnt    = sw_q;

endmodule
